// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO sequencer and its wait timer.
//   OP_*            : op_code encodings from the control unit
//   hilo_state_t    : sequencer state encoding
//   TIMEOUT_DEFAULT : cycles allowed in WAIT before giving up
//   CNT_W_DEFAULT   : wait counter width (2**CNT_W must exceed TIMEOUT)
package hilo_pkg;

    localparam logic [1:0] OP_MULT = 2'd0;
    localparam logic [1:0] OP_DIV  = 2'd1;
    localparam logic [1:0] OP_MTHI = 2'd2;
    localparam logic [1:0] OP_MTLO = 2'd3;

    localparam int TIMEOUT_DEFAULT = 40;
    localparam int CNT_W_DEFAULT   = 6;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE_M = 3'd1,
        ST_WAIT_M  = 3'd2,
        ST_ISSUE_D = 3'd3,
        ST_WAIT_D  = 3'd4,
        ST_FINISH  = 3'd5
    } hilo_state_t;

endpackage

// File: rtl/hilo_unit_wait_timer.sv
// Clearable up-counter with a timeout compare, shared by the multi-cycle
// sequencers.
//   clock, reset : clock and synchronous active-high reset
//   clear        : force count to zero (wins over enable)
//   enable       : advance the count by one this cycle
//   expired      : this is the TIMEOUT-th enabled cycle since the clear;
//                  the edge that ends it brings the count to TIMEOUT
module wait_timer #(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register owner and sequencer for the multiplier and divider.
//   clock, reset             : clock, synchronous active-high reset
//   op_valid/op_code/wdata   : request from control (sampled in IDLE only)
//   mult_start/div_start     : one-cycle registered start pulses
//   mult_*/div_*             : functional-unit results and done flags
//   hi, lo                   : architectural registers (combinational read)
//   busy, op_done, op_error  : status to control
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for op_valid
// ISSUE_M  | mult_start high, timer cleared, mult_done ignored (stale)
// WAIT_M   | counting until mult_done or timeout
// ISSUE_D  | div_start high, timer cleared, div_done ignored (stale)
// WAIT_D   | counting until div_done or timeout
// FINISH   | exactly one of op_done / op_error high
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [1:0]  op_code,
    input  logic [31:0] wdata,
    output logic        mult_start,
    input  logic        mult_done,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    output logic        div_start,
    input  logic        div_done,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    input  logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        op_done,
    output logic        op_error
);
    hilo_state_t state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        mult_start_q, mult_start_d;
    logic        div_start_q, div_start_d;
    logic        busy_q, busy_d;
    logic        op_done_q, op_done_d;
    logic        op_error_q, op_error_d;

    logic timer_clr;
    logic timer_en;
    logic timer_expired;

    wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wait_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (timer_clr),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        timer_clr  = 1'b0;
        timer_en   = 1'b0;
        op_done_d  = 1'b0;
        op_error_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    case (op_code)
                        OP_MULT: state_d = ST_ISSUE_M;
                        OP_DIV:  state_d = ST_ISSUE_D;
                        OP_MTHI: begin
                            hi_d      = wdata;
                            op_done_d = 1'b1;
                            state_d   = ST_FINISH;
                        end
                        OP_MTLO: begin
                            lo_d      = wdata;
                            op_done_d = 1'b1;
                            state_d   = ST_FINISH;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_ISSUE_M: begin
                timer_clr = 1'b1;
                state_d   = ST_WAIT_M;
            end
            ST_WAIT_M: begin
                timer_en = 1'b1;
                // done is checked first so it wins over a same-cycle timeout
                if (mult_done) begin
                    hi_d      = mult_hi;
                    lo_d      = mult_lo;
                    op_done_d = 1'b1;
                    state_d   = ST_FINISH;
                end else if (timer_expired) begin
                    op_error_d = 1'b1;
                    state_d    = ST_FINISH;
                end
            end
            ST_ISSUE_D: begin
                timer_clr = 1'b1;
                state_d   = ST_WAIT_D;
            end
            ST_WAIT_D: begin
                timer_en = 1'b1;
                if (div_done) begin
                    if (div_zero) begin
                        op_error_d = 1'b1;
                    end else begin
                        hi_d      = div_hi;
                        lo_d      = div_lo;
                        op_done_d = 1'b1;
                    end
                    state_d = ST_FINISH;
                end else if (timer_expired) begin
                    op_error_d = 1'b1;
                    state_d    = ST_FINISH;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // Status outputs are registered copies of the state being entered
        mult_start_d = (state_d == ST_ISSUE_M);
        div_start_d  = (state_d == ST_ISSUE_D);
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            hi_q         <= '0;
            lo_q         <= '0;
            mult_start_q <= 1'b0;
            div_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            op_done_q    <= 1'b0;
            op_error_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            mult_start_q <= mult_start_d;
            div_start_q  <= div_start_d;
            busy_q       <= busy_d;
            op_done_q    <= op_done_d;
            op_error_q   <= op_error_d;
        end
    end

    assign hi         = hi_q;
    assign lo         = lo_q;
    assign mult_start = mult_start_q;
    assign div_start  = div_start_q;
    assign busy       = busy_q;
    assign op_done    = op_done_q;
    assign op_error   = op_error_q;

endmodule
